writeback_unit: RTL and testbench

- Producer side of the integer/float register-file write port.
- Collects results from three sources: the single-cycle ALU, the multi-cycle FPU and the load/store unit (LSU).
- Issues at most one register write per cycle as {wb_rd, rddata, we}.
- Keeps a 64-entry busy scoreboard so decode can stall on pending destinations.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/writeback_unit.sv | 140 ++++++++++++++
 tb/tb_writeback_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback path.
package wb_pkg;

  localparam int unsigned REG_INT_BASE = 0;
  localparam int unsigned REG_FLT_BASE = 32;

  typedef struct packed {
    logic       en;
    logic [5:0] idx;
  } wb_dest_t;

  typedef struct packed {
    wb_dest_t    rd;
    logic [31:0] data;
  } wb_entry_t;

  // Regs 0 and 32 are hardwired zero, so only idx[4:0] matters.
  function automatic logic is_null_dest(wb_dest_t d);
    return !d.en || (d.idx[4:0] == 5'd0);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency (FPU/LSU) results awaiting a write slot.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  wb_entry_t                i_entry,
  input  logic                     i_pop,
  output wb_entry_t                o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wb_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

  // Ignore requests that would overflow or underflow.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage write; contents need no reset since head is only used when non-empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_entry;
    end
  end

  // Pointers wrap naturally at DEPTH (power of 2); count tracks push minus pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port producer: arbitrates ALU and queued FPU/LSU results
// into one registered write per cycle and tracks pending destinations.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREG  = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_issue_valid,
  input  logic [6:0]  i_issue_rd,
  input  logic        i_alu_valid,
  input  logic [6:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_fpu_valid,
  output logic        o_fpu_ready,
  input  logic [6:0]  i_fpu_rd,
  input  logic [31:0] i_fpu_data,
  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic [6:0]  i_lsu_rd,
  input  logic [31:0] i_lsu_data,
  input  logic [5:0]  i_rs1,
  input  logic [5:0]  i_rs2,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic [6:0]  o_wb_rd,
  output logic [31:0] o_rddata,
  output logic        o_we
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_d;
  logic            r_we;
  wb_dest_t        r_wb_rd;
  logic [31:0]     r_rddata;

  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  wb_entry_t       w_head;
  wb_entry_t       w_push_entry;
  wb_entry_t       w_sel;
  logic            w_fpu_fire;
  logic            w_lsu_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_alu_sel;
  logic            w_wr_sel;
  logic            w_issue_set;

  // FPU wins the single enqueue slot; ready depends only on the current count,
  // so a same-cycle pop never makes room for a push.
  assign o_fpu_ready = (w_count < CW'(DEPTH));
  assign o_lsu_ready = !w_full && !i_fpu_valid;

  assign w_fpu_fire = i_fpu_valid && o_fpu_ready;
  assign w_lsu_fire = i_lsu_valid && o_lsu_ready;

  // Null-destination results complete the handshake but are dropped here.
  always_comb begin
    w_push       = 1'b0;
    w_push_entry = '{rd: wb_dest_t'(i_lsu_rd), data: i_lsu_data};
    if (w_fpu_fire) begin
      w_push       = !is_null_dest(wb_dest_t'(i_fpu_rd));
      w_push_entry = '{rd: wb_dest_t'(i_fpu_rd), data: i_fpu_data};
    end else if (w_lsu_fire) begin
      w_push       = !is_null_dest(wb_dest_t'(i_lsu_rd));
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // ALU has no backpressure, so it always takes the write slot over the FIFO.
  always_comb begin
    w_alu_sel = i_alu_valid && !is_null_dest(wb_dest_t'(i_alu_rd));
    w_pop     = !w_alu_sel && !w_empty;
    w_wr_sel  = w_alu_sel || w_pop;
    w_sel     = w_alu_sel ? '{rd: wb_dest_t'(i_alu_rd), data: i_alu_data} : w_head;
  end

  // Scoreboard next state: clear on selected write, then set on issue so the
  // newer instruction keeps ownership when both hit the same register.
  always_comb begin
    w_issue_set = i_issue_valid && !is_null_dest(wb_dest_t'(i_issue_rd));
    w_busy_d    = r_busy;
    if (w_wr_sel) begin
      w_busy_d[w_sel.rd.idx] = 1'b0;
    end
    if (w_issue_set) begin
      w_busy_d[i_issue_rd[5:0]] = 1'b1;
    end
  end

  // Scoreboard state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  // Registered write port; rd/data hold their last value when no write issues.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we     <= 1'b0;
      r_wb_rd  <= '0;
      r_rddata <= '0;
    end else begin
      r_we <= w_wr_sel;
      if (w_wr_sel) begin
        r_wb_rd  <= w_sel.rd;
        r_rddata <= w_sel.data;
      end
    end
  end

  assign o_we       = r_we;
  assign o_wb_rd    = r_wb_rd;
  assign o_rddata   = r_rddata;
  assign o_rs1_busy = r_busy[i_rs1] && (i_rs1[4:0] != 5'd0);
  assign o_rs2_busy = r_busy[i_rs2] && (i_rs2[4:0] != 5'd0);

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a reference model and write scoreboard.
module tb_writeback_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [6:0]  issue_rd;
  logic        alu_valid;
  logic [6:0]  alu_rd;
  logic [31:0] alu_data;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [6:0]  fpu_rd;
  logic [31:0] fpu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [6:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [5:0]  rs1;
  logic [5:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [6:0]  wb_rd;
  logic [31:0] rddata;
  logic        we;

  writeback_unit #(
    .DEPTH (DEPTH),
    .NREG  (64)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .i_alu_valid   (alu_valid),
    .i_alu_rd      (alu_rd),
    .i_alu_data    (alu_data),
    .i_fpu_valid   (fpu_valid),
    .o_fpu_ready   (fpu_ready),
    .i_fpu_rd      (fpu_rd),
    .i_fpu_data    (fpu_data),
    .i_lsu_valid   (lsu_valid),
    .o_lsu_ready   (lsu_ready),
    .i_lsu_rd      (lsu_rd),
    .i_lsu_data    (lsu_data),
    .i_rs1         (rs1),
    .i_rs2         (rs2),
    .o_rs1_busy    (rs1_busy),
    .o_rs2_busy    (rs2_busy),
    .o_wb_rd       (wb_rd),
    .o_rddata      (rddata),
    .o_we          (we)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state: queued long-latency results, expected writes, busy bits.
  logic [38:0] mq[$];
  logic [38:0] exp_q[$];
  logic [63:0] m_busy;
  logic [38:0] m_last;
  logic        m_we;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic nul(input logic [6:0] rd);
    return !rd[6] || (rd[4:0] == 5'd0);
  endfunction

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = '0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    fpu_valid = 0; fpu_rd = '0; fpu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
  endtask

  task automatic chk_busy();
    chk("rs1_busy", 64'(rs1_busy), 64'(m_busy[rs1] && (rs1[4:0] != 5'd0)));
    chk("rs2_busy", 64'(rs2_busy), 64'(m_busy[rs2] && (rs2[4:0] != 5'd0)));
  endtask

  // One clock with the current inputs: predict, step, compare.
  task automatic cycle();
    logic        fr, lr, alu_s, pop;
    logic [38:0] e;
    #1;
    fr = (mq.size() < DEPTH);
    lr = fr && !fpu_valid;
    chk("fpu_ready", 64'(fpu_ready), 64'(fr));
    chk("lsu_ready", 64'(lsu_ready), 64'(lr));
    alu_s = alu_valid && !nul(alu_rd);
    pop   = !alu_s && (mq.size() != 0);
    e     = '0;
    if (alu_s)    e = {alu_rd, alu_data};
    else if (pop) e = mq.pop_front();
    if (alu_s || pop) begin
      exp_q.push_back(e);
      m_busy[e[37:32]] = 1'b0;
    end
    if (fpu_valid && fr) begin
      if (!nul(fpu_rd)) mq.push_back({fpu_rd, fpu_data});
    end else if (lsu_valid && lr) begin
      if (!nul(lsu_rd)) mq.push_back({lsu_rd, lsu_data});
    end
    if (issue_valid && !nul(issue_rd)) m_busy[issue_rd[5:0]] = 1'b1;
    m_we = alu_s || pop;
    @(posedge clk);
    #1;
    chk("we", 64'(we), 64'(m_we));
    if (m_we && exp_q.size() != 0) m_last = exp_q.pop_front();
    chk("wb_rd", 64'(wb_rd), 64'(m_last[38:32]));
    chk("rddata", 64'(rddata), 64'(m_last[31:0]));
    chk_busy();
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    mq.delete();
    exp_q.delete();
    m_busy = '0;
    m_last = '0;
    m_we   = 0;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    chk("rst_rddata", 64'(rddata), 64'd0);
    chk("rst_fpu_ready", 64'(fpu_ready), 64'd1);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    chk_busy();
  endtask

  initial begin
    idle_inputs();
    rst = 1; rs1 = 6'h03; rs2 = 6'h0A;
    m_busy = '0; m_last = '0; m_we = 0;
    @(posedge clk);
    do_reset();

    // Single ALU write, then an idle cycle.
    alu_valid = 1; alu_rd = 7'h45; alu_data = 32'hDEADBEEF;
    cycle();
    chk("alu_we", 64'(we), 64'd1);
    chk("alu_rd", 64'(wb_rd), 64'h45);
    chk("alu_data", 64'(rddata), 64'hDEADBEEF);
    idle_inputs();
    cycle();
    chk("alu_we_drop", 64'(we), 64'd0);

    // Issue to x3, then complete it via the FPU.
    issue_valid = 1; issue_rd = 7'h43;
    cycle();
    chk("busy_x3_set", 64'(rs1_busy), 64'd1);
    idle_inputs();
    fpu_valid = 1; fpu_rd = 7'h43; fpu_data = 32'd5;
    cycle();
    idle_inputs();
    cycle();
    chk("fpu_write_rd", 64'(wb_rd), 64'h43);
    chk("busy_x3_clear", 64'(rs1_busy), 64'd0);

    // FPU and LSU contend; FPU first, then LSU.
    fpu_valid = 1; fpu_rd = 7'h44; fpu_data = 32'h1;
    lsu_valid = 1; lsu_rd = 7'h46; lsu_data = 32'h2;
    cycle();
    fpu_valid = 0;
    cycle();
    idle_inputs();
    repeat (3) cycle();

    // Fill the FIFO behind a stream of ALU writes, then drain in order.
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 7'h47; alu_data = 32'h100 + 32'(i);
      fpu_valid = 1; fpu_rd = 7'h48 + 7'(i); fpu_data = 32'hF00 + 32'(i);
      cycle();
    end
    alu_data = 32'h200; fpu_rd = 7'h4F; fpu_data = 32'hF0F;
    cycle();
    alu_valid = 0;
    cycle();
    idle_inputs();
    repeat (6) cycle();

    // Null destinations: no write, no busy change.
    alu_valid = 1; alu_rd = 7'h40; alu_data = 32'h11;
    issue_valid = 1; issue_rd = 7'h60; rs1 = 6'h20;
    cycle();
    alu_rd = 7'h05; issue_rd = 7'h05; rs2 = 6'h05;
    cycle();
    idle_inputs();
    lsu_valid = 1; lsu_rd = 7'h20; lsu_data = 32'h33;
    cycle();
    idle_inputs();
    cycle();

    // Same-cycle set and clear of x10: set wins.
    rs1 = 6'h03; rs2 = 6'h0A;
    issue_valid = 1; issue_rd = 7'h4A;
    alu_valid = 1; alu_rd = 7'h4A; alu_data = 32'hA5A5;
    cycle();
    chk("busy_x10_set_wins", 64'(rs2_busy), 64'd1);

    // Queue three results, then reset mid-operation.
    idle_inputs();
    issue_valid = 1; issue_rd = 7'h4E; rs1 = 6'h0E;
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      alu_valid = 1; alu_rd = 7'h4C; alu_data = 32'h300 + 32'(i);
      fpu_valid = 1; fpu_rd = 7'h4D; fpu_data = 32'h400 + 32'(i);
      cycle();
    end
    idle_inputs();
    do_reset();
    chk("rst_clears_x10", 64'(rs2_busy), 64'd0);
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
